// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_fetch_pkg;

  // Default datapath widths for the pipeline front end.
  localparam int IF_PC_WIDTH    = 14;
  localparam int IF_INSTR_WIDTH = 16;

  // First fetch address after reset and the bubble encoding used on squash/refill.
  localparam logic [IF_PC_WIDTH-1:0]    IF_RESET_PC  = '0;
  localparam logic [IF_INSTR_WIDTH-1:0] IF_NOP_INSTR = 16'h0000;

  // REFILL: memory is not yet returning data for pc_q (after reset or redirect).
  // RUN:    memory data for pc_d1 is on imem_data_mem this cycle.
  // HOLD:   decode is stalled and the presented instruction lives in the skid register.
  typedef enum logic [1:0] {
    REFILL = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_skid_buffer.sv
// Skid register and output mux selecting what fetch presents to decode.
// Latency: combinational mux; skid capture takes effect the cycle after a RUN stall.
// Backpressure: captures memory data when a stall hits in RUN, replays it until released.
module fetch_skid_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int                     INSTR_WIDTH = IF_INSTR_WIDTH,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = IF_NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  fetch_state_t           state,
  input  logic                   capture,
  input  logic                   kill,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   valid
);

  logic [INSTR_WIDTH-1:0] skid_q;

  // Save the word decode did not take; memory moves on to re-reading pc_q meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= NOP_INSTR;
    end else if (capture) begin
      skid_q <= mem_data;
    end
  end

  // Pick the presented word by state; a same-cycle redirect squashes it to a bubble.
  always_comb begin
    instruction = NOP_INSTR;
    valid       = 1'b0;
    if (!kill) begin
      case (state)
        RUN: begin
          instruction = mem_data;
          valid       = 1'b1;
        end
        HOLD: begin
          instruction = skid_q;
          valid       = 1'b1;
        end
        default: begin
          instruction = NOP_INSTR;
          valid       = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the 1-cycle synchronous imem, feeds decode.
// Latency: first valid instruction one cycle after reset release or redirect, then one per cycle.
// Backpressure: stall_hz freezes the PC and replays the presented word from a skid register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                     PC_WIDTH    = IF_PC_WIDTH,
  parameter int                     INSTR_WIDTH = IF_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = IF_RESET_PC,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = IF_NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_hz,
  input  logic                   mispredict_ex,
  input  logic [PC_WIDTH-1:0]    correct_target_ex,
  input  logic                   predict_taken_id,
  input  logic [PC_WIDTH-1:0]    target_address_id,
  output logic [PC_WIDTH-1:0]    imem_addr_if,
  input  logic [INSTR_WIDTH-1:0] imem_data_mem,
  output logic [INSTR_WIDTH-1:0] instruction_if,
  output logic [PC_WIDTH-1:0]    next_program_counter_if,
  output logic [PC_WIDTH-1:0]    fetch_pc_if,
  output logic                   valid_if
);

  // pc_q is the address in flight to memory; pc_d1 is the address whose data returns now.
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d1;
  fetch_state_t        state_q;

  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                skid_capture;

  // Execute redirects always win; a decode redirect is dropped while stalled and reasserted later.
  always_comb begin
    redirect        = 1'b0;
    redirect_target = target_address_id;
    if (mispredict_ex) begin
      redirect        = 1'b1;
      redirect_target = correct_target_ex;
    end else if (predict_taken_id && !stall_hz) begin
      redirect        = 1'b1;
      redirect_target = target_address_id;
    end
  end

  // Only a stall landing in RUN has live memory data that must be parked.
  assign skid_capture = (state_q == RUN) && stall_hz && !redirect;

  // PC and fetch state: redirect, then stall, then sequential advance (wraps silently).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      pc_d1   <= RESET_PC;
      state_q <= REFILL;
    end else if (redirect) begin
      pc_q    <= redirect_target;
      state_q <= REFILL;
    end else if (stall_hz) begin
      if (state_q == RUN) begin
        state_q <= HOLD;
      end
    end else begin
      pc_d1   <= pc_q;
      pc_q    <= pc_q + PC_WIDTH'(1);
      state_q <= RUN;
    end
  end

  fetch_skid_buffer #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .NOP_INSTR   (NOP_INSTR)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state_q),
    .capture     (skid_capture),
    .kill        (redirect),
    .mem_data    (imem_data_mem),
    .instruction (instruction_if),
    .valid       (valid_if)
  );

  assign imem_addr_if            = pc_q;
  assign fetch_pc_if             = pc_d1;
  assign next_program_counter_if = pc_d1 + PC_WIDTH'(1);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with an address-stream reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_instruction_fetch;

  localparam int               PCW      = 14;
  localparam int               IW       = 16;
  localparam logic [PCW-1:0]   RST_PC   = 14'h0000;
  localparam logic [IW-1:0]    NOP      = 16'h0000;

  logic           clk;
  logic           rst_n;
  logic           stall_hz;
  logic           mispredict_ex;
  logic [PCW-1:0] correct_target_ex;
  logic           predict_taken_id;
  logic [PCW-1:0] target_address_id;
  logic [PCW-1:0] imem_addr_if;
  logic [IW-1:0]  imem_data_mem;
  logic [IW-1:0]  instruction_if;
  logic [PCW-1:0] next_program_counter_if;
  logic [PCW-1:0] fetch_pc_if;
  logic           valid_if;

  int n_cmp = 0;
  int n_bad = 0;

  instruction_fetch #(
    .PC_WIDTH    (PCW),
    .INSTR_WIDTH (IW),
    .RESET_PC    (RST_PC),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .stall_hz                (stall_hz),
    .mispredict_ex           (mispredict_ex),
    .correct_target_ex       (correct_target_ex),
    .predict_taken_id        (predict_taken_id),
    .target_address_id       (target_address_id),
    .imem_addr_if            (imem_addr_if),
    .imem_data_mem           (imem_data_mem),
    .instruction_if          (instruction_if),
    .next_program_counter_if (next_program_counter_if),
    .fetch_pc_if             (fetch_pc_if),
    .valid_if                (valid_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory, contents mem[k] = 16'h1000 + k.
  always @(posedge clk) imem_data_mem <= 16'h1000 + {2'b00, imem_addr_if};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: which program address decode is shown, and which comes next.
  logic           mdl_vld;
  logic [PCW-1:0] mdl_cur;
  logic [PCW-1:0] mdl_next;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_vld  = 1'b0;
      mdl_cur  = RST_PC;
      mdl_next = RST_PC;
    end else if (mispredict_ex) begin
      mdl_vld  = 1'b0;
      mdl_next = correct_target_ex;
    end else if (predict_taken_id && !stall_hz) begin
      mdl_vld  = 1'b0;
      mdl_next = target_address_id;
    end else if (!stall_hz) begin
      mdl_vld  = 1'b1;
      mdl_cur  = mdl_next;
      mdl_next = mdl_next + 14'd1;
    end
  end

  // Every cycle: compare DUT outputs against the model.
  always @(negedge clk) begin
    logic           kill;
    logic           ev;
    logic [PCW-1:0] e_addr;
    kill   = mispredict_ex || (predict_taken_id && !stall_hz);
    ev     = mdl_vld && !kill && rst_n;
    e_addr = mdl_vld ? mdl_cur + 14'd1 : mdl_next;
    chk("m_valid", {31'd0, valid_if}, {31'd0, ev});
    chk("m_imem_addr", {18'd0, imem_addr_if}, {18'd0, e_addr});
    chk("m_instr", {16'd0, instruction_if}, ev ? {16'd0, 16'h1000 + {2'b00, mdl_cur}} : {16'd0, NOP});
    if (ev) begin
      chk("m_fetch_pc", {18'd0, fetch_pc_if}, {18'd0, mdl_cur});
      chk("m_next_pc", {18'd0, next_program_counter_if}, {18'd0, mdl_cur + 14'd1});
    end
  end

  logic [11:0] stall_pat;

  initial begin
    rst_n             = 1'b1;
    stall_hz          = 1'b0;
    mispredict_ex     = 1'b0;
    correct_target_ex = '0;
    predict_taken_id  = 1'b0;
    target_address_id = '0;
    stall_pat         = 12'b0011_0100_1011;
    #1 rst_n = 1'b0;
    repeat (2) tick();

    // Reset state.
    @(negedge clk);
    chk("rst_addr", {18'd0, imem_addr_if}, 32'h0);
    chk("rst_instr", {16'd0, instruction_if}, 32'h0);
    chk("rst_valid", {31'd0, valid_if}, 32'h0);
    chk("rst_fetch_pc", {18'd0, fetch_pc_if}, 32'h0);
    chk("rst_next_pc", {18'd0, next_program_counter_if}, 32'h1);

    // Release: one bubble, then sequential stream.
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_bubble", {31'd0, valid_if}, 32'h0);
    tick();
    @(negedge clk);
    chk("first_instr", {16'd0, instruction_if}, 32'h1000);
    chk("first_next_pc", {18'd0, next_program_counter_if}, 32'h1);
    chk("first_valid", {31'd0, valid_if}, 32'h1);
    repeat (3) tick();

    // Stall three cycles while 16'h1003 is presented.
    stall_hz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_instr", {16'd0, instruction_if}, 32'h1003);
      chk("stall_valid", {31'd0, valid_if}, 32'h1);
      chk("stall_addr", {18'd0, imem_addr_if}, 32'h4);
      tick();
    end
    stall_hz = 1'b0;
    @(negedge clk);
    chk("release_instr", {16'd0, instruction_if}, 32'h1003);
    tick();
    @(negedge clk);
    chk("after_stall", {16'd0, instruction_if}, 32'h1004);
    chk("after_stall_pc", {18'd0, fetch_pc_if}, 32'h4);

    // Predicted-taken redirect to 0x40.
    tick();
    predict_taken_id  = 1'b1;
    target_address_id = 14'h0040;
    @(negedge clk);
    chk("pred_kill_valid", {31'd0, valid_if}, 32'h0);
    chk("pred_kill_instr", {16'd0, instruction_if}, 32'h0);
    tick();
    predict_taken_id = 1'b0;
    @(negedge clk);
    chk("pred_refill_valid", {31'd0, valid_if}, 32'h0);
    chk("pred_refill_addr", {18'd0, imem_addr_if}, 32'h40);
    tick();
    @(negedge clk);
    chk("pred_target_instr", {16'd0, instruction_if}, 32'h1040);
    chk("pred_target_npc", {18'd0, next_program_counter_if}, 32'h41);

    // Mispredict and predict together under stall: execute target wins.
    tick();
    mispredict_ex     = 1'b1;
    correct_target_ex = 14'h0100;
    predict_taken_id  = 1'b1;
    target_address_id = 14'h0040;
    stall_hz          = 1'b1;
    @(negedge clk);
    chk("mis_kill_valid", {31'd0, valid_if}, 32'h0);
    tick();
    mispredict_ex    = 1'b0;
    predict_taken_id = 1'b0;
    stall_hz         = 1'b0;
    @(negedge clk);
    chk("mis_refill_addr", {18'd0, imem_addr_if}, 32'h100);
    tick();
    @(negedge clk);
    chk("mis_target_instr", {16'd0, instruction_if}, 32'h1100);
    chk("mis_target_pc", {18'd0, fetch_pc_if}, 32'h100);

    // PC wrap-around at 14'h3FFF.
    tick();
    mispredict_ex     = 1'b1;
    correct_target_ex = 14'h3FFD;
    tick();
    mispredict_ex = 1'b0;
    tick();
    @(negedge clk);
    chk("wrap_first", {16'd0, instruction_if}, 32'h4FFD);
    repeat (2) tick();
    @(negedge clk);
    chk("wrap_top_instr", {16'd0, instruction_if}, 32'h4FFF);
    chk("wrap_top_npc", {18'd0, next_program_counter_if}, 32'h0);
    chk("wrap_top_addr", {18'd0, imem_addr_if}, 32'h0);
    tick();
    @(negedge clk);
    chk("wrap_zero_instr", {16'd0, instruction_if}, 32'h1000);
    chk("wrap_zero_pc", {18'd0, fetch_pc_if}, 32'h0);

    // Redirect then a stall pattern, including stalls during refill.
    tick();
    mispredict_ex     = 1'b1;
    correct_target_ex = 14'h0200;
    tick();
    mispredict_ex = 1'b0;
    for (int i = 11; i >= 0; i--) begin
      stall_hz = stall_pat[i];
      tick();
    end
    stall_hz = 1'b0;
    repeat (2) tick();

    // Reset asserted mid-HOLD.
    stall_hz = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("hold_valid", {31'd0, valid_if}, 32'h1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_addr", {18'd0, imem_addr_if}, 32'h0);
    chk("midrst_valid", {31'd0, valid_if}, 32'h0);
    chk("midrst_instr", {16'd0, instruction_if}, 32'h0);
    tick();
    stall_hz = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_bubble", {31'd0, valid_if}, 32'h0);
    tick();
    @(negedge clk);
    chk("postrst_instr", {16'd0, instruction_if}, 32'h1000);
    chk("postrst_pc", {18'd0, fetch_pc_if}, 32'h0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Pipeline stage directly upstream of InstructionDecode.
- Owns the program counter and drives the synchronous instruction memory, which has 1-cycle read latency.
- Presents instruction_if and next_program_counter_if to decode, which registers them on clk.
- Handles hazard stalls (skid buffer), predicted-taken redirects from decode and mispredict redirects from execute, squashing wrong-path fetches as NOPs.

Parameters:
- PC_WIDTH, 14, program counter / instruction address width
- INSTR_WIDTH, 16, instruction word width
- RESET_PC, 0, first fetch address after reset
- NOP_INSTR, 16'h0000, bubble instruction injected on squash/refill

Ports:
- clk  in  1  stage clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_hz  in  1  hazard stall: decode holds; fetch must hold and not lose the presented instruction
- mispredict_ex  in  1  execute-stage redirect, highest priority
- correct_target_ex  in  PC_WIDTH  redirect target for mispredict_ex
- predict_taken_id  in  1  decode saw a predicted-taken branch
- target_address_id  in  PC_WIDTH  target for predict_taken_id
- imem_addr_if  out  PC_WIDTH  instruction memory address (= pc_q)
- imem_data_mem  in  INSTR_WIDTH  memory read data for the address presented the previous cycle
- instruction_if  out  INSTR_WIDTH  instruction to decode
- next_program_counter_if  out  PC_WIDTH  fetch_pc_if+1, mod 2^PC_WIDTH
- fetch_pc_if  out  PC_WIDTH  address of instruction_if (branch predictor index)
- valid_if  out  1  instruction_if is a real (non-bubble) instruction

Behaviour:
- Registers:
  - pc_q: address in flight.
  - pc_d1: address of data now returning.
  - skid_q: INSTR_WIDTH.
  - state_q: REFILL, RUN or HOLD.
- Reset (async, immediate, also mid-operation):
  - pc_q = pc_d1 = RESET_PC, skid_q = NOP_INSTR, state_q = REFILL.
  - Outputs during and after reset: imem_addr_if = RESET_PC, instruction_if = NOP_INSTR, valid_if = 0, fetch_pc_if = RESET_PC, next_program_counter_if = RESET_PC+1.
- Redirect priority, evaluated each cycle:
  1. mispredict_ex: acts even when stall_hz = 1.
  2. predict_taken_id: ignored when stall_hz = 1; decode reasserts it.
  3. stall_hz.
  4. Sequential fetch.
- Redirect in any state:
  - pc_q <= target, state_q <= REFILL.
  - Same cycle, combinationally: instruction_if = NOP_INSTR, valid_if = 0 (wrong-path kill).
- Output mux:
  - REFILL: NOP_INSTR with valid 0.
  - RUN: imem_data_mem with valid 1.
  - HOLD: skid_q with valid 1.
  - fetch_pc_if = pc_d1 in all states.
- REFILL:
  - Memory is not yet returning data for pc_q.
  - No stall: pc_d1 <= pc_q, pc_q <= pc_q+1, go to RUN.
  - Stall: hold all registers, stay in REFILL.
- RUN:
  - No stall: pc_d1 <= pc_q, pc_q <= pc_q+1, stay in RUN.
  - Stall: skid_q <= imem_data_mem, pc_q and pc_d1 hold, go to HOLD. Memory re-reads pc_q, which is harmless.
- HOLD:
  - Stall: hold, stay in HOLD. Output is skid_q, stable.
  - No stall: decode consumes skid_q. Then pc_d1 <= pc_q, pc_q <= pc_q+1, go to RUN; the next cycle returns the data for the old pc_q.
- Latency:
  - First valid instruction appears one cycle after rst_n deasserts or after a redirect.
  - Thereafter one instruction per unstalled cycle.
- Wrap-around: pc_q+1 at 2^PC_WIDTH-1 wraps to 0, with no flag.
- Simultaneous mispredict_ex and predict_taken_id: correct_target_ex wins.

Decomposition:
- Shared pipeline package holds:
  - PC_WIDTH and INSTR_WIDTH constants.
  - NOP_INSTR encoding.
  - The fetch state enum (REFILL/RUN/HOLD).
- One natural sub-module: fetch_skid_buffer, holding skid_q plus the output mux driving instruction_if/valid_if.
- The PC/next-state logic stays in the top module.

Test Plan:
- Reset then free-run with mem[k] = 16'h1000+k:
  - Cycle 1: NOP/valid 0.
  - Then instruction_if = 16'h1000, 16'h1001, ... with next_program_counter_if = 1, 2, ...
- stall_hz high for 3 cycles while instruction_if = 16'h1003:
  - Output stays 16'h1003/valid 1 and imem_addr_if is frozen.
  - After release: 16'h1004 next cycle, no duplicate, no gap.
- predict_taken_id with target_address_id = 14'h0040:
  - Same cycle: NOP/valid 0.
  - Next cycle: NOP (REFILL).
  - Then instruction from 0x40 with next_program_counter_if = 14'h0041.
- mispredict_ex (target 14'h0100) and predict_taken_id (target 14'h0040) together, with stall_hz = 1:
  - Fetch resumes at 0x100.
  - predict ignored.
- Run to pc_q = 14'h3FFF:
  - Next fetch address is 0.
  - next_program_counter_if for 0x3FFF is 0.
- Assert rst_n low mid-HOLD:
  - Immediately imem_addr_if = RESET_PC, valid_if = 0, state REFILL.
  - Skid contents discarded.
